load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_if.sv | 24 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-size helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unknown encodings fall back to a word access.
    function automatic acc_size_t access_size(input logic [2:0] funct3, input logic is_store);
        acc_size_t sz;
        sz = SZ_WORD;
        if (is_store) begin
            if (funct3 == F3_SB)      sz = SZ_BYTE;
            else if (funct3 == F3_SH) sz = SZ_HALF;
            else if (funct3 == F3_SW) sz = SZ_WORD;
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      sz = SZ_BYTE;
            else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/gnt/rvalid bus between the load/store unit and memory.
interface lsu_if;
    import lsu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replication and load extraction / extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic              st_is_store,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] lane_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ext
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        be        = 4'b1111;
        lane_data = st_data;
        case (access_size(st_funct3, st_is_store))
            SZ_BYTE: begin
                be        = 4'b0001 << st_off;
                lane_data = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << st_off;
                lane_data = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = raw >> {ld_off, 3'b000};

    always_comb begin
        ext = raw;
        case (ld_funct3)
            F3_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  ext = {24'd0, shifted[7:0]};
            F3_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  ext = {16'd0, shifted[15:0]};
            F3_LW:   ext = raw;
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid transaction per instruction, stalls until done.
// Optional handshake watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_misalign,
    output logic              lsu_err,
    lsu_if.master             mem
);

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              accept;
    logic              misalign_n;
    logic [3:0]        be_n;
    logic [DATA_W-1:0] lane_n;
    logic [DATA_W-1:0] ext_n;

    assign accept     = ex_valid & (ex_mem_read | ex_mem_write);
    assign misalign_n = is_misaligned(access_size(ex_funct3, ex_mem_write), ex_addr[1:0]);
    assign lsu_busy   = (state == IDLE && accept) || state == REQ || state == WAIT;

    lsu_align u_align (
        .st_funct3   (ex_funct3),
        .st_is_store (ex_mem_write),
        .st_off      (ex_addr[1:0]),
        .st_data     (ex_wdata),
        .be          (be_n),
        .lane_data   (lane_n),
        .ld_funct3   (f3_q),
        .ld_off      (off_q),
        .raw         (mem.mem_rdata),
        .ext         (ext_n)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;
    assign wd_expired = (32'(wd_cnt) == TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign lsu_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            f3_q           <= '0;
            off_q          <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_be     <= '0;
            mem.mem_wdata  <= '0;
            lsu_done       <= 1'b0;
            lsu_misalign   <= 1'b0;
            lsu_rdata      <= '0;
`ifdef LSU_TIMEOUT_EN
            lsu_err        <= 1'b0;
            wd_cnt         <= '0;
`endif
        end else begin
            lsu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q          <= ex_mem_write;
                        f3_q          <= ex_funct3;
                        off_q         <= ex_addr[1:0];
                        mem.mem_we    <= ex_mem_write;
                        mem.mem_addr  <= {ex_addr[DATA_W-1:2], 2'b00};
                        mem.mem_be    <= be_n;
                        mem.mem_wdata <= ex_mem_write ? lane_n : '0;
                        if (misalign_n) begin
                            state        <= DONE;
                            lsu_done     <= 1'b1;
                            lsu_misalign <= 1'b1;
                        end else begin
                            state        <= REQ;
                            mem.mem_req  <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                            wd_cnt       <= '0;
`endif
                        end
                    end
                end
                REQ: begin
`ifdef LSU_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        if (we_q) begin
                            state    <= DONE;
                            lsu_done <= 1'b1;
                        end else begin
                            state    <= WAIT;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wd_expired) begin
                        mem.mem_req <= 1'b0;
                        state       <= DONE;
                        lsu_done    <= 1'b1;
                        lsu_err     <= 1'b1;
                        lsu_rdata   <= '0;
                    end
`endif
                end
                WAIT: begin
`ifdef LSU_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                    if (mem.mem_rvalid) begin
                        lsu_rdata <= ext_n;
                        state     <= DONE;
                        lsu_done  <= 1'b1;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wd_expired) begin
                        state     <= DONE;
                        lsu_done  <= 1'b1;
                        lsu_err   <= 1'b1;
                        lsu_rdata <= '0;
                    end
`endif
                end
                DONE: begin
                    state        <= IDLE;
                    lsu_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                    lsu_err      <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus per-cycle compare process.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned TO = 8;
`ifdef LSU_TIMEOUT_EN
    localparam bit TIMEOUT_BUILD = 1'b1;
`else
    localparam bit TIMEOUT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_busy, lsu_done, lsu_misalign, lsu_err;
    logic [31:0] lsu_rdata;

    lsu_if mem ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .lsu_busy     (lsu_busy),
        .lsu_done     (lsu_done),
        .lsu_rdata    (lsu_rdata),
        .lsu_misalign (lsu_misalign),
        .lsu_err      (lsu_err),
        .mem          (mem)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          is_st;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          misalign;
        bit          err;
        bit          ld_done;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          done_cyc;
        int          busy_cyc;
        int          req_cyc;
        logic [3:0]  be0;
        logic [31:0] wdata0;
        logic [31:0] addr0;
        logic [31:0] rdata;
        logic        misalign;
        logic        err;
    } res_t;

    exp_t        exp_q[$];
    logic [31:0] model_rdata;

    // Transaction model: derive everything from access width in bytes and the byte offset.
    function automatic exp_t model(bit is_st, logic [2:0] f3, logic [31:0] addr,
                                   logic [31:0] wd, logic [31:0] rd, bit timeout);
        exp_t        e;
        int          nbytes;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        off = int'(addr[1:0]);
        if (is_st) nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else       nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        e.is_st    = is_st;
        e.addr     = addr - 32'(off);
        e.be       = 4'(((1 << nbytes) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        e.misalign = (off % nbytes) != 0;
        e.err      = timeout && !e.misalign;
        mask       = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nbytes)) - 1);
        v          = (rd >> (8 * off)) & mask;
        if (nbytes < 4 && (f3 == 3'd0 || f3 == 3'd1) && v[8*nbytes-1]) v = v | ~mask;
        e.rdata    = e.err ? 32'd0 : v;
        e.ld_done  = e.err || (!is_st && !e.misalign);
        return e;
    endfunction

    exp_t cur;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (mem.mem_req) begin
                check("req_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("mem_addr", mem.mem_addr, exp_q[0].addr);
                    check("mem_be", 32'(mem.mem_be), 32'(exp_q[0].be));
                    check("mem_we", 32'(mem.mem_we), 32'(exp_q[0].is_st));
                    check("req_on_misaligned", 32'(exp_q[0].misalign), 32'd0);
                    if (exp_q[0].is_st) check("mem_wdata", mem.mem_wdata, exp_q[0].wdata);
                end
            end
            if (lsu_done) begin
                check("done_single_pulse", 32'(prev_done), 32'd0);
                check("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("lsu_misalign", 32'(lsu_misalign), 32'(cur.misalign));
                    check("lsu_err", 32'(lsu_err), 32'(cur.err));
                    if (cur.ld_done) model_rdata = cur.rdata;
                end
            end
            check("lsu_rdata", lsu_rdata, model_rdata);
            prev_done = lsu_done;
        end
    end

    // Drives one instruction and plays the memory side; gnt after gnt_wait REQ cycles,
    // rvalid rv_wait cycles after gnt, optional junk rvalid in the gnt cycle.
    task automatic access(input bit is_st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gnt_wait, input int rv_wait, input bit junk_rv,
                          output res_t r);
        exp_t e;
        bit   to;
        bit   granted;
        int   gcyc;
        int   exp_done;
        int   exp_req;
        to = TIMEOUT_BUILD && gnt_wait >= int'(TO);
        e  = model(is_st, f3, addr, wd, rd, to);
        if (e.misalign)      begin exp_done = 2;                        exp_req = 0; end
        else if (e.err)      begin exp_done = 2 + int'(TO);             exp_req = int'(TO); end
        else if (is_st)      begin exp_done = 3 + gnt_wait;             exp_req = gnt_wait + 1; end
        else                 begin exp_done = 3 + gnt_wait + rv_wait;   exp_req = gnt_wait + 1; end
        exp_q.push_back(e);
        r = '{default: '0};
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = !is_st; ex_mem_write = is_st;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
        granted = 1'b0; gcyc = 0;
        for (int c = 1; c <= 300 && r.done_cyc == 0; c++) begin
            mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'hDEAD_BEEF;
            if (mem.mem_req) begin
                if (r.req_cyc == 0) begin
                    r.be0 = mem.mem_be; r.wdata0 = mem.mem_wdata; r.addr0 = mem.mem_addr;
                end
                r.req_cyc++;
                if (r.req_cyc > gnt_wait) begin
                    mem.mem_gnt = 1'b1; granted = 1'b1; gcyc = c;
                    if (junk_rv) mem.mem_rvalid = 1'b1;
                end
            end else if (granted && c == gcyc + rv_wait) begin
                mem.mem_rvalid = 1'b1; mem.mem_rdata = rd;
            end
            @(negedge clk);
            if (lsu_busy) r.busy_cyc++;
            if (lsu_done) begin
                r.done_cyc = c; r.rdata = lsu_rdata; r.misalign = lsu_misalign; r.err = lsu_err;
            end
            @(posedge clk); #1;
            ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        end
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
        check("done_latency", 32'(r.done_cyc), 32'(exp_done));
        check("busy_cycles", 32'(r.busy_cyc), 32'(exp_done - 1));
        check("req_cycles", 32'(r.req_cyc), 32'(exp_req));
        if (r.done_cyc == 0) void'(exp_q.pop_back());
    endtask

    res_t r;

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        model_rdata = '0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem.mem_req), 32'd0);
        check("rst_done", 32'(lsu_done), 32'd0);
        check("rst_busy", 32'(lsu_busy), 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        check("rst_misalign", 32'(lsu_misalign), 32'd0);
        check("rst_err", 32'(lsu_err), 32'd0);
        check("rst_be", 32'(mem.mem_be), 32'd0);

        // SB lane replication into the top byte.
        access(1'b1, F3_SB, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 1, 1'b0, r);
        check("sb_be_lit", 32'(r.be0), 32'h8);
        check("sb_wdata_lit", r.wdata0, 32'hDDDD_DDDD);
        check("sb_addr_lit", r.addr0, 32'h0000_1000);
        check("sb_done_lit", 32'(r.done_cyc), 32'd3);

        access(1'b0, F3_LH, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 2, 1'b0, r);
        check("lh_rdata_lit", r.rdata, 32'hFFFF_8001);
        access(1'b0, F3_LHU, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 2, 1'b0, r);
        check("lhu_rdata_lit", r.rdata, 32'h0000_8001);

        access(1'b0, F3_LW, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 1'b0, r);
        check("lw_mis_flag_lit", 32'(r.misalign), 32'd1);
        check("lw_mis_busy_lit", 32'(r.busy_cyc), 32'd1);
        check("lw_mis_req_lit", 32'(r.req_cyc), 32'd0);
        check("lw_mis_rdata_hold", lsu_rdata, 32'h0000_8001);

        access(1'b1, F3_SW, 32'h0000_3004, 32'h1122_3344, 32'h0, 5, 1, 1'b0, r);
        check("sw_stall_req_lit", 32'(r.req_cyc), 32'd6);
        check("sw_stall_done_lit", 32'(r.done_cyc), 32'd8);

        access(1'b0, F3_LB,  32'h0000_6002, 32'h0, 32'h12F4_5678, 1, 1, 1'b1, r);
        check("lb_rdata_lit", r.rdata, 32'hFFFF_FFF4);
        access(1'b0, F3_LBU, 32'h0000_6003, 32'h0, 32'h9A00_0000, 0, 3, 1'b0, r);
        access(1'b1, F3_SH,  32'h0000_7002, 32'h0000_BEEF, 32'h0, 2, 1, 1'b0, r);
        check("sh_wdata_lit", r.wdata0, 32'hBEEF_BEEF);
        access(1'b1, F3_SH,  32'h0000_7001, 32'h0000_BEEF, 32'h0, 0, 1, 1'b0, r);
        access(1'b1, 3'b100, 32'h0000_8000, 32'hCAFE_F00D, 32'h0, 0, 1, 1'b0, r);
        access(1'b1, 3'b100, 32'h0000_8002, 32'hCAFE_F00D, 32'h0, 0, 1, 1'b0, r);
        access(1'b0, 3'b011, 32'h0000_9000, 32'h0, 32'h8765_4321, 0, 1, 1'b0, r);
        access(1'b0, F3_LH,  32'h0000_9003, 32'h0, 32'h0, 0, 1, 1'b0, r);
        access(1'b0, F3_LB,  32'h0000_9003, 32'h0, 32'h7F00_0000, 0, 1, 1'b0, r);
        check("lb_pos_rdata_lit", r.rdata, 32'h0000_007F);

        // Reset while a load waits for rvalid.
        exp_q.push_back(model(1'b0, F3_LW, 32'h0000_4000, 32'h0, 32'h0, 1'b0));
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = F3_LW; ex_addr = 32'h0000_4000;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        check("rw_req_seen", 32'(mem.mem_req), 32'd1);
        mem.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem.mem_gnt = 1'b0;
        check("rw_wait_busy", 32'(lsu_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rw_mem_req", 32'(mem.mem_req), 32'd0);
        check("rw_mem_addr", mem.mem_addr, 32'd0);
        check("rw_mem_be", 32'(mem.mem_be), 32'd0);
        check("rw_mem_we", 32'(mem.mem_we), 32'd0);
        check("rw_mem_wdata", mem.mem_wdata, 32'd0);
        check("rw_done", 32'(lsu_done), 32'd0);
        check("rw_rdata", lsu_rdata, 32'd0);
        check("rw_busy", 32'(lsu_busy), 32'd0);
        exp_q.delete();
        model_rdata = '0;
        @(posedge clk);
        #3 reset = 1'b0;
        access(1'b0, F3_LW, 32'h0000_5000, 32'h0, 32'h1234_5678, 0, 1, 1'b0, r);
        check("post_rst_lw_lit", r.rdata, 32'h1234_5678);
        check("post_rst_done_lit", 32'(r.done_cyc), 32'd4);

        if (TIMEOUT_BUILD) begin
            access(1'b0, F3_LW, 32'h0000_A000, 32'h0, 32'h5555_5555, 1000, 1, 1'b0, r);
            check("to_err_lit", 32'(r.err), 32'd1);
            check("to_rdata_lit", r.rdata, 32'd0);
            check("to_done_lit", 32'(r.done_cyc), 32'd10);
            check("to_req_dropped", 32'(mem.mem_req), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
